alu_unit: RTL and testbench



---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_shifter.sv | 34 +++
 rtl/alu_unit.sv | 119 +++++++++++
 tb/tb_alu_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and widths for the registered execute-stage ALU.
package alu_pkg;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned SHAMT_W = 5;

  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    AND = 4'd2,
    OR  = 4'd3,
    XOR = 4'd4,
    NOT = 4'd5,
    SLA = 4'd6,
    SRA = 4'd7,
    SRL = 4'd8
  } alu_funct_e;

  typedef enum logic [1:0] {
    SH_LEFT  = 2'd0,
    SH_ARITH = 2'd1,
    SH_LOGIC = 2'd2
  } shift_mode_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter: left, arithmetic right or logical right,
// also returning the last bit shifted out (0 for a zero shift amount).
module alu_shifter
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0]   a_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  shift_mode_e        mode_i,
  output logic [WIDTH-1:0]   res_o_c,
  output logic               last_o_c
);

  logic [WIDTH:0] left_ext;
  logic [WIDTH:0] right_ext;

  // One guard bit beyond the data catches the last bit shifted out.
  always_comb begin
    left_ext  = {1'b0, a_i} << shamt_i;
    right_ext = {a_i, 1'b0} >> shamt_i;
    if (mode_i == SH_ARITH) begin
      right_ext = $signed({a_i, 1'b0}) >>> shamt_i;
    end
  end

  always_comb begin
    res_o_c  = right_ext[WIDTH:1];
    last_o_c = right_ext[0];
    if (mode_i == SH_LEFT) begin
      res_o_c  = left_ext[WIDTH-1:0];
      last_o_c = left_ext[WIDTH];
    end
  end

endmodule

// File: rtl/alu_unit.sv
// Registered 32-bit ALU: nine operations selected by funct, one-cycle latency.
// Optional zero/neg/carry/ovf flag outputs are built when ALU_FLAGS_EN is defined.
module alu_unit
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [3:0]         funct,
  output logic [WIDTH-1:0]   out
`ifdef ALU_FLAGS_EN
  ,
  output logic               zero,
  output logic               neg,
  output logic               carry,
  output logic               ovf
`endif
);

  alu_funct_e      op;
  shift_mode_e     sh_mode;
  logic [WIDTH-1:0] sh_res;
  logic            sh_last;
  logic [WIDTH:0]  add_ext;
  logic [WIDTH:0]  sub_ext;
  logic [WIDTH-1:0] out_d, out_q;

  assign op = alu_funct_e'(funct);

  always_comb begin
    sh_mode = SH_LOGIC;
    if (op == SLA) sh_mode = SH_LEFT;
    else if (op == SRA) sh_mode = SH_ARITH;
  end

  alu_shifter u_shifter (
    .a_i      (a),
    .shamt_i  (shamt),
    .mode_i   (sh_mode),
    .res_o_c  (sh_res),
    .last_o_c (sh_last)
  );

  // Subtraction as a + ~b + 1 so the carry-out means "no borrow".
  assign add_ext = {1'b0, a} + {1'b0, b};
  assign sub_ext = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);

  always_comb begin
    out_d = '0;
    case (op)
      ADD:     out_d = add_ext[WIDTH-1:0];
      SUB:     out_d = sub_ext[WIDTH-1:0];
      AND:     out_d = a & b;
      OR:      out_d = a | b;
      XOR:     out_d = a ^ b;
      NOT:     out_d = ~a;
      SLA,
      SRA,
      SRL:     out_d = sh_res;
      default: out_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= out_d;
  end

  assign out = out_q;

`ifdef ALU_FLAGS_EN
  logic carry_d, ovf_d;
  logic zero_q, neg_q, carry_q, ovf_q;

  always_comb begin
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    case (op)
      ADD: begin
        carry_d = add_ext[WIDTH];
        ovf_d   = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
      end
      SUB: begin
        carry_d = sub_ext[WIDTH];
        ovf_d   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ext[WIDTH-1] != a[WIDTH-1]);
      end
      SLA,
      SRA,
      SRL:     carry_d = sh_last;
      default: carry_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      zero_q  <= (out_d == '0);
      neg_q   <= out_d[WIDTH-1];
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign zero  = zero_q;
  assign neg   = neg_q;
  assign carry = carry_q;
  assign ovf   = ovf_q;
`else
  logic [2:0] unused_bits;
  assign unused_bits = {sh_last, add_ext[WIDTH], sub_ext[WIDTH]};
`endif

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed cases plus random operations
// against an arithmetic reference model (flag checks when ALU_FLAGS_EN is set).
module tb_alu_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic [3:0]  funct;
  logic [31:0] out;
`ifdef ALU_FLAGS_EN
  logic zero, neg, carry, ovf;
`endif

  int checks = 0;
  int errors = 0;

  alu_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .shamt (shamt),
    .funct (funct),
    .out   (out)
`ifdef ALU_FLAGS_EN
    ,
    .zero  (zero),
    .neg   (neg),
    .carry (carry),
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic longint pow2(input int s);
    longint p = 1;
    for (int i = 0; i < s; i++) p = p * 2;
    return p;
  endfunction

  // Reference result from plain integer arithmetic.
  function automatic logic [31:0] ref_r(input logic [31:0] ra, input logic [31:0] rb,
                                         input logic [4:0] rs, input logic [3:0] rf);
    longint sa = longint'($signed(ra));
    longint sb = longint'($signed(rb));
    longint ua = longint'({32'd0, ra});
    longint p  = pow2(int'(rs));
    longint res;
    case (rf)
      4'd0: res = sa + sb;
      4'd1: res = sa - sb;
      4'd2: res = longint'({32'd0, ra & rb});
      4'd3: res = longint'({32'd0, ra | rb});
      4'd4: res = longint'({32'd0, ra ^ rb});
      4'd5: res = -sa - 1;
      4'd6: res = ua * p;
      4'd7: res = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
      4'd8: res = ua / p;
      default: res = 0;
    endcase
    return res[31:0];
  endfunction

  // Reference flags {zero, neg, carry, ovf}.
  function automatic logic [3:0] ref_f(input logic [31:0] ra, input logic [31:0] rb,
                                        input logic [4:0] rs, input logic [3:0] rf);
    logic [31:0] r = ref_r(ra, rb, rs, rf);
    longint sa = longint'($signed(ra));
    longint sb = longint'($signed(rb));
    longint ua = longint'({32'd0, ra});
    longint ub = longint'({32'd0, rb});
    longint lim = pow2(31);
    longint t;
    logic c = 1'b0;
    logic v = 1'b0;
    case (rf)
      4'd0: begin
        c = (ua + ub) >= pow2(32);
        t = sa + sb;
        v = (t >= lim) || (t < -lim);
      end
      4'd1: begin
        c = ua >= ub;
        t = sa - sb;
        v = (t >= lim) || (t < -lim);
      end
      4'd6: if (rs != 0) begin
        t = (ua * pow2(int'(rs))) / pow2(32);
        c = t[0];
      end
      4'd7, 4'd8: if (rs != 0) begin
        t = ua / pow2(int'(rs) - 1);
        c = t[0];
      end
      default: c = 1'b0;
    endcase
    return {r == 32'd0, r[31], c, v};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [31:0] ta, input logic [31:0] tb2,
                       input logic [4:0] ts, input logic [3:0] tf);
    a = ta; b = tb2; shamt = ts; funct = tf;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [4:0]  rs;
    logic [3:0]  rf;

    rst_n = 1'b0; a = 32'd5; b = 32'd5; shamt = 5'd0; funct = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold", out, 32'd0);
`ifdef ALU_FLAGS_EN
    check("rst_flags", 32'({zero, neg, carry, ovf}), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_capture", out, 32'd10);
    #2 rst_n = 1'b0;
    #1 check("rst_async", out, 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release", out, 32'd10);

    apply(32'hFFFF_FFEC, 32'd3, 5'd0, 4'd0); check("add", out, 32'hFFFF_FFEF);
    apply(32'hFFFF_FFEC, 32'd3, 5'd0, 4'd1); check("sub", out, 32'hFFFF_FFE9);
    apply(32'hFFFF_FFEC, 32'd3, 5'd0, 4'd2); check("and", out, 32'd0);
    apply(32'hFFFF_FFEC, 32'd3, 5'd0, 4'd3); check("or", out, 32'hFFFF_FFEF);
    apply(32'hFFFF_FFEC, 32'd3, 5'd0, 4'd4); check("xor", out, 32'hFFFF_FFEF);
    apply(32'hFFFF_FFEC, 32'd3, 5'd0, 4'd5); check("not", out, 32'd19);
    apply(32'hFFFF_FFEC, 32'd3, 5'd0, 4'd6); check("sla0", out, 32'hFFFF_FFEC);
    apply(32'hFFFF_FFEC, 32'd3, 5'd4, 4'd6); check("sla4", out, 32'hFFFF_FEC0);
    apply(32'hFFFF_FFEC, 32'd3, 5'd2, 4'd7); check("sra2", out, 32'hFFFF_FFFB);
    apply(32'hFFFF_FFEC, 32'd3, 5'd2, 4'd8); check("srl2", out, 32'h3FFF_FFFB);
    apply(32'hFFFF_FFEC, 32'd3, 5'd31, 4'd7); check("sra31", out, 32'hFFFF_FFFF);
    apply(32'hFFFF_FFEC, 32'd3, 5'd7, 4'd12); check("reserved", out, 32'd0);
`ifdef ALU_FLAGS_EN
    apply(32'h7FFF_FFFF, 32'd1, 5'd0, 4'd0);
    check("ovf_out", out, 32'h8000_0000);
    check("ovf_flag", 32'(ovf), 32'd1);
    check("neg_flag", 32'(neg), 32'd1);
`endif

    apply(32'hFFFF_FFEC, 32'd3, 5'd0, 4'd0);
    funct = 4'd1;
    #3 check("no_comb_path", out, 32'hFFFF_FFEF);
    @(posedge clk);
    #1 check("sub_after_edge", out, 32'hFFFF_FFE9);

    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 7 == 0) ra = 32'h8000_0000 ^ 32'($urandom_range(0, 3));
      if (i % 11 == 0) rb = ra;
      rs = 5'($urandom_range(0, 31));
      rf = 4'($urandom_range(0, 15));
      apply(ra, rb, rs, rf);
      check("rand_out", out, ref_r(ra, rb, rs, rf));
`ifdef ALU_FLAGS_EN
      check("rand_flags", 32'({zero, neg, carry, ovf}), 32'(ref_f(ra, rb, rs, rf)));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
